// File: rtl/l2_arbiter.sv
// Two-requester L2 arbiter: round-robin between C0/C1, write-back before read, one downstream op at a time.
// Latency: grant in IDLE; read request goes downstream the next cycle, response forwarded combinationally.
// Backpressure: requesters hold valid until served; WR_REQ holds the downstream write until L2_S_W_READY.
module l2_arbiter #(
    parameter int ADDR_WIDTH = 64,
    parameter int LINE_WIDTH = 512
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] C0_R_ADDR,
    input  logic [ADDR_WIDTH-1:0] C1_R_ADDR,
    input  logic                  C0_R_ADDR_VALID,
    input  logic                  C1_R_ADDR_VALID,
    output logic [LINE_WIDTH-1:0] C0_R_DATA,
    output logic [LINE_WIDTH-1:0] C1_R_DATA,
    output logic                  C0_R_DATA_VALID,
    output logic                  C1_R_DATA_VALID,
    input  logic                  C0_W_VALID,
    input  logic                  C1_W_VALID,
    input  logic [ADDR_WIDTH-1:0] C0_W_ADDR,
    input  logic [ADDR_WIDTH-1:0] C1_W_ADDR,
    input  logic [LINE_WIDTH-1:0] C0_W_DATA,
    input  logic [LINE_WIDTH-1:0] C1_W_DATA,
    output logic                  C0_W_READY,
    output logic                  C1_W_READY,
    output logic                  C0_W_COMPLETE,
    output logic                  C1_W_COMPLETE,
    output logic [ADDR_WIDTH-1:0] L2_S_R_ADDR,
    output logic                  L2_S_R_ADDR_VALID,
    input  logic [LINE_WIDTH-1:0] L2_S_R_DATA,
    input  logic                  L2_S_R_DATA_VALID,
    output logic                  L2_S_W_VALID,
    output logic [ADDR_WIDTH-1:0] L2_S_W_ADDR,
    output logic [LINE_WIDTH-1:0] L2_S_W_DATA,
    input  logic                  L2_S_W_READY,
    input  logic                  L2_S_W_COMPLETE
);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT} state_t;

    state_t                state, state_nxt;
    logic                  last_grant, last_grant_nxt;
    logic                  gnt, gnt_nxt;
    logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
    logic [LINE_WIDTH-1:0] data_q, data_nxt;

    logic                  req0, req1, any_req, pick, pick_wr;
    logic [1:0]            r_dv, w_rdy, w_cmp;

    // Round-robin pick: the requester not granted last gets first look
    always_comb begin
        req0    = C0_W_VALID | C0_R_ADDR_VALID;
        req1    = C1_W_VALID | C1_R_ADDR_VALID;
        any_req = req0 | req1;
        if (last_grant) begin
            pick = ~req0;
        end else begin
            pick = req1;
        end
        pick_wr = pick ? C1_W_VALID : C0_W_VALID;
    end

    // Next-state, latch updates and outputs; reset forces every output low combinationally
    always_comb begin
        state_nxt         = state;
        last_grant_nxt    = last_grant;
        gnt_nxt           = gnt;
        addr_nxt          = addr_q;
        data_nxt          = data_q;
        r_dv              = 2'b00;
        w_rdy             = 2'b00;
        w_cmp             = 2'b00;
        L2_S_R_ADDR_VALID = 1'b0;
        L2_S_R_ADDR       = '0;
        L2_S_W_VALID      = 1'b0;
        L2_S_W_ADDR       = '0;
        L2_S_W_DATA       = '0;
        case (state)
            IDLE: begin
                if (any_req && !reset) begin
                    gnt_nxt        = pick;
                    last_grant_nxt = pick;
                    if (pick_wr) begin
                        addr_nxt    = pick ? C1_W_ADDR : C0_W_ADDR;
                        data_nxt    = pick ? C1_W_DATA : C0_W_DATA;
                        w_rdy[pick] = 1'b1;
                        state_nxt   = WR_REQ;
                    end else begin
                        addr_nxt  = pick ? C1_R_ADDR : C0_R_ADDR;
                        state_nxt = RD_REQ;
                    end
                end
            end
            RD_REQ: begin
                L2_S_R_ADDR_VALID = 1'b1;
                L2_S_R_ADDR       = addr_q;
                state_nxt         = RD_WAIT;
            end
            RD_WAIT: begin
                L2_S_R_ADDR_VALID = 1'b1;
                L2_S_R_ADDR       = addr_q;
                if (L2_S_R_DATA_VALID) begin
                    r_dv[gnt] = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WR_REQ: begin
                L2_S_W_VALID = 1'b1;
                L2_S_W_ADDR  = addr_q;
                L2_S_W_DATA  = data_q;
                if (L2_S_W_READY) begin
                    state_nxt = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (L2_S_W_COMPLETE) begin
                    w_cmp[gnt] = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (reset) begin
            r_dv              = 2'b00;
            w_rdy             = 2'b00;
            w_cmp             = 2'b00;
            L2_S_R_ADDR_VALID = 1'b0;
            L2_S_R_ADDR       = '0;
            L2_S_W_VALID      = 1'b0;
            L2_S_W_ADDR       = '0;
            L2_S_W_DATA       = '0;
        end
    end

    // Requester-facing outputs: only the granted side ever sees a pulse or data
    always_comb begin
        C0_R_DATA_VALID = r_dv[0];
        C1_R_DATA_VALID = r_dv[1];
        C0_R_DATA       = r_dv[0] ? L2_S_R_DATA : '0;
        C1_R_DATA       = r_dv[1] ? L2_S_R_DATA : '0;
        C0_W_READY      = w_rdy[0];
        C1_W_READY      = w_rdy[1];
        C0_W_COMPLETE   = w_cmp[0];
        C1_W_COMPLETE   = w_cmp[1];
    end

    // State and latched transaction registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            gnt        <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            gnt        <= gnt_nxt;
            addr_q     <= addr_nxt;
            data_q     <= data_nxt;
        end
    end

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed vector bench for l2_arbiter: per-cycle input/expected-output table plus a reset-during-write sequence.
// Inputs are driven just after the falling edge and outputs sampled 1ns later, before the next rising edge.
// Requester address/data can be scrambled per vector to prove the downstream side uses latched values.
module tb_l2_arbiter;

    localparam logic [63:0]  RA0 = 64'h1000;
    localparam logic [63:0]  RA1 = 64'h3000;
    localparam logic [63:0]  WA0 = 64'h4080;
    localparam logic [63:0]  WA1 = 64'h2040;
    localparam logic [511:0] WD0 = {16{32'hC0C0_0001}};
    localparam logic [511:0] WD1 = {16{32'hC1C1_0002}};
    localparam logic [511:0] SRD = {16{32'hDDDD_1234}};

    // expected-flag bits: {C0_R_DV, C1_R_DV, C0_W_RDY, C1_W_RDY, C0_W_CMP, C1_W_CMP, L2_R_AV, L2_W_V}
    localparam logic [7:0] F_R0 = 8'h80, F_R1 = 8'h40, F_W0R = 8'h20, F_W1R = 8'h10;
    localparam logic [7:0] F_W0C = 8'h08, F_W1C = 8'h04, F_RA = 8'h02, F_WV = 8'h01;

    logic         clk = 1'b0;
    logic         reset;
    logic [63:0]  C0_R_ADDR, C1_R_ADDR, C0_W_ADDR, C1_W_ADDR, L2_S_R_ADDR, L2_S_W_ADDR;
    logic         C0_R_ADDR_VALID, C1_R_ADDR_VALID, C0_W_VALID, C1_W_VALID;
    logic [511:0] C0_R_DATA, C1_R_DATA, C0_W_DATA, C1_W_DATA, L2_S_R_DATA, L2_S_W_DATA;
    logic         C0_R_DATA_VALID, C1_R_DATA_VALID, C0_W_READY, C1_W_READY;
    logic         C0_W_COMPLETE, C1_W_COMPLETE, L2_S_R_ADDR_VALID, L2_S_R_DATA_VALID;
    logic         L2_S_W_VALID, L2_S_W_READY, L2_S_W_COMPLETE;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    l2_arbiter dut (
        .clk(clk), .reset(reset),
        .C0_R_ADDR(C0_R_ADDR), .C1_R_ADDR(C1_R_ADDR),
        .C0_R_ADDR_VALID(C0_R_ADDR_VALID), .C1_R_ADDR_VALID(C1_R_ADDR_VALID),
        .C0_R_DATA(C0_R_DATA), .C1_R_DATA(C1_R_DATA),
        .C0_R_DATA_VALID(C0_R_DATA_VALID), .C1_R_DATA_VALID(C1_R_DATA_VALID),
        .C0_W_VALID(C0_W_VALID), .C1_W_VALID(C1_W_VALID),
        .C0_W_ADDR(C0_W_ADDR), .C1_W_ADDR(C1_W_ADDR),
        .C0_W_DATA(C0_W_DATA), .C1_W_DATA(C1_W_DATA),
        .C0_W_READY(C0_W_READY), .C1_W_READY(C1_W_READY),
        .C0_W_COMPLETE(C0_W_COMPLETE), .C1_W_COMPLETE(C1_W_COMPLETE),
        .L2_S_R_ADDR(L2_S_R_ADDR), .L2_S_R_ADDR_VALID(L2_S_R_ADDR_VALID),
        .L2_S_R_DATA(L2_S_R_DATA), .L2_S_R_DATA_VALID(L2_S_R_DATA_VALID),
        .L2_S_W_VALID(L2_S_W_VALID), .L2_S_W_ADDR(L2_S_W_ADDR), .L2_S_W_DATA(L2_S_W_DATA),
        .L2_S_W_READY(L2_S_W_READY), .L2_S_W_COMPLETE(L2_S_W_COMPLETE)
    );

    typedef struct {
        logic         rst;
        logic [3:0]   req;   // {C1_W, C0_W, C1_R, C0_R}
        logic         scr;   // drive inverted requester address/data
        logic [2:0]   rsp;   // {L2_S_R_DATA_VALID, L2_S_W_READY, L2_S_W_COMPLETE}
        logic [7:0]   flg;
        logic [63:0]  ea;    // expected downstream address (read or write)
        logic [511:0] ewd;   // expected downstream write data
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic [3:0] req, input logic scr, input logic [2:0] rsp,
                       input logic [7:0] flg, input logic [63:0] ea, input logic [511:0] ewd);
        vec_t v;
        v.rst = rst; v.req = req; v.scr = scr; v.rsp = rsp; v.flg = flg; v.ea = ea; v.ewd = ewd;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic [3:0] req, input logic scr, input logic [2:0] rsp);
        reset             = rst;
        C0_R_ADDR_VALID   = req[0];
        C1_R_ADDR_VALID   = req[1];
        C0_W_VALID        = req[2];
        C1_W_VALID        = req[3];
        C0_R_ADDR         = scr ? ~RA0 : RA0;
        C1_R_ADDR         = scr ? ~RA1 : RA1;
        C0_W_ADDR         = scr ? ~WA0 : WA0;
        C1_W_ADDR         = scr ? ~WA1 : WA1;
        C0_W_DATA         = scr ? ~WD0 : WD0;
        C1_W_DATA         = scr ? ~WD1 : WD1;
        L2_S_R_DATA       = SRD;
        L2_S_R_DATA_VALID = rsp[2];
        L2_S_W_READY      = rsp[1];
        L2_S_W_COMPLETE   = rsp[0];
    endtask

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        drive(1'b1, 4'b0000, 1'b0, 3'b000);

        // reset with a pending request: outputs held low; then C0 read, data 3 cycles after the request
        add(1, 4'b0001, 0, 3'b000, 8'h00, 0, 0);
        add(1, 4'b0001, 0, 3'b000, 8'h00, 0, 0);
        add(0, 4'b0001, 0, 3'b000, 8'h00, 0, 0);             // grant C0 read
        add(0, 4'b0001, 0, 3'b000, F_RA, RA0, 0);            // RD_REQ
        add(0, 4'b0001, 1, 3'b000, F_RA, RA0, 0);            // RD_WAIT, inputs scrambled
        add(0, 4'b0001, 1, 3'b000, F_RA, RA0, 0);
        add(0, 4'b0001, 0, 3'b100, F_RA | F_R0, RA0, 0);     // response to C0 only
        add(0, 4'b0000, 0, 3'b000, 8'h00, 0, 0);
        // contention after reset: C0, C1, C0, C1
        add(1, 4'b0011, 0, 3'b000, 8'h00, 0, 0);
        add(0, 4'b0011, 0, 3'b000, 8'h00, 0, 0);
        add(0, 4'b0011, 0, 3'b000, F_RA, RA0, 0);
        add(0, 4'b0011, 0, 3'b100, F_RA | F_R0, RA0, 0);
        add(0, 4'b0010, 0, 3'b000, 8'h00, 0, 0);             // C1 waited while busy
        add(0, 4'b0010, 0, 3'b000, F_RA, RA1, 0);
        add(0, 4'b0010, 0, 3'b100, F_RA | F_R1, RA1, 0);
        add(0, 4'b0011, 0, 3'b000, 8'h00, 0, 0);
        add(0, 4'b0011, 0, 3'b000, F_RA, RA0, 0);
        add(0, 4'b0011, 0, 3'b100, F_RA | F_R0, RA0, 0);
        add(0, 4'b0010, 0, 3'b000, 8'h00, 0, 0);
        add(0, 4'b0010, 0, 3'b000, F_RA, RA1, 0);
        add(0, 4'b0010, 0, 3'b100, F_RA | F_R1, RA1, 0);
        add(0, 4'b0000, 0, 3'b000, 8'h00, 0, 0);
        // C1 write-back and read together: write first, then read
        add(0, 4'b1010, 0, 3'b000, F_W1R, 0, 0);
        add(0, 4'b0010, 0, 3'b010, F_WV, WA1, WD1);
        add(0, 4'b0010, 0, 3'b000, 8'h00, 0, 0);
        add(0, 4'b0010, 0, 3'b001, F_W1C, 0, 0);
        add(0, 4'b0010, 0, 3'b000, 8'h00, 0, 0);
        add(0, 4'b0010, 0, 3'b000, F_RA, RA1, 0);
        add(0, 4'b0010, 0, 3'b100, F_RA | F_R1, RA1, 0);
        add(0, 4'b0000, 0, 3'b000, 8'h00, 0, 0);
        // C0 write with downstream ready low for 5 cycles
        add(0, 4'b0100, 0, 3'b000, F_W0R, 0, 0);
        for (int k = 0; k < 5; k++) add(0, 4'b0000, 1, 3'b000, F_WV, WA0, WD0);
        add(0, 4'b0000, 0, 3'b010, F_WV, WA0, WD0);
        add(0, 4'b0000, 0, 3'b000, 8'h00, 0, 0);             // WR_WAIT
        add(0, 4'b0000, 0, 3'b001, F_W0C, 0, 0);
        add(0, 4'b0000, 0, 3'b000, 8'h00, 0, 0);
        // reset in RD_WAIT abandons the read; late data is ignored; C0 wins again
        add(0, 4'b0001, 0, 3'b000, 8'h00, 0, 0);
        add(0, 4'b0001, 0, 3'b000, F_RA, RA0, 0);
        add(0, 4'b0001, 0, 3'b000, F_RA, RA0, 0);
        add(1, 4'b0001, 0, 3'b100, 8'h00, 0, 0);
        add(0, 4'b0000, 0, 3'b100, 8'h00, 0, 0);
        add(0, 4'b0000, 0, 3'b100, 8'h00, 0, 0);
        add(0, 4'b0011, 0, 3'b000, 8'h00, 0, 0);
        add(0, 4'b0011, 0, 3'b000, F_RA, RA0, 0);
        add(0, 4'b0011, 0, 3'b100, F_RA | F_R0, RA0, 0);
        add(0, 4'b0000, 0, 3'b000, 8'h00, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            vec_t v;
            logic [7:0] act_flg;
            v = tbl[i];
            @(negedge clk);
            drive(v.rst, v.req, v.scr, v.rsp);
            #1;
            act_flg = {C0_R_DATA_VALID, C1_R_DATA_VALID, C0_W_READY, C1_W_READY,
                       C0_W_COMPLETE, C1_W_COMPLETE, L2_S_R_ADDR_VALID, L2_S_W_VALID};
            check($sformatf("v%0d flags", i), 512'(act_flg), 512'(v.flg));
            check($sformatf("v%0d l2_r_addr", i), 512'(L2_S_R_ADDR), 512'(v.flg[1] ? v.ea : 64'h0));
            check($sformatf("v%0d l2_w_addr", i), 512'(L2_S_W_ADDR), 512'(v.flg[0] ? v.ea : 64'h0));
            check($sformatf("v%0d l2_w_data", i), L2_S_W_DATA, v.flg[0] ? v.ewd : 512'h0);
            check($sformatf("v%0d c0_r_data", i), C0_R_DATA, v.flg[7] ? SRD : 512'h0);
            check($sformatf("v%0d c1_r_data", i), C1_R_DATA, v.flg[6] ? SRD : 512'h0);
        end

        // reset while a C1 write is pending downstream: no completion afterwards
        @(negedge clk); drive(1'b0, 4'b1000, 1'b0, 3'b000); #1;
        check("wr_rst grant c1_w_ready", 512'(C1_W_READY), 512'(1'b1));
        check("wr_rst grant c0_w_ready", 512'(C0_W_READY), 512'(1'b0));
        @(negedge clk); drive(1'b0, 4'b0000, 1'b0, 3'b000); #1;
        check("wr_rst l2_w_valid", 512'(L2_S_W_VALID), 512'(1'b1));
        check("wr_rst l2_w_addr", 512'(L2_S_W_ADDR), 512'(WA1));
        @(negedge clk); drive(1'b1, 4'b0000, 1'b0, 3'b000); #1;
        check("wr_rst in reset l2_w_valid", 512'(L2_S_W_VALID), 512'(1'b0));
        @(negedge clk); drive(1'b0, 4'b0000, 1'b0, 3'b011); #1;
        check("wr_rst after l2_w_valid", 512'(L2_S_W_VALID), 512'(1'b0));
        check("wr_rst after c1_w_complete", 512'(C1_W_COMPLETE), 512'(1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
